// File: rtl/dac_spi_pkg.sv
// Shared types and elaboration helpers for the multi-channel DAC SPI master.
package dac_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, FIN} state_e;

  function automatic int frame_w(input int ctrlW, input int dataW);
    return ctrlW + dataW;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Serialises one frame: a setup half-period with SCLK high, then one low/high
// SCLK period per bit, with data advancing on the rising edge only.
module dac_spi_shifter import dac_spi_pkg::*; #(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  output logic               sclk,
  output logic               sout,
  output logic               frame_done
);

  localparam int DIV_W = clog2(CLK_DIV + 1);
  localparam int BIT_W = clog2(FRAME_W + 1);

  logic               active_q, active_d;
  logic               sclk_q, sclk_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               divEnd;

  assign divEnd = (div_q == DIV_W'(CLK_DIV - 1));

  // bit_q counts completed rising edges; the frame ends after the high half
  // that follows the last one.
  always_comb begin
    active_d   = active_q;
    sclk_d     = sclk_q;
    sreg_d     = sreg_q;
    div_d      = div_q;
    bit_d      = bit_q;
    frame_done = 1'b0;
    if (load) begin
      active_d = 1'b1;
      sclk_d   = 1'b1;
      sreg_d   = word;
      div_d    = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (!divEnd) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        if (sclk_q) begin
          if (bit_q == BIT_W'(FRAME_W)) begin
            frame_done = 1'b1;
            active_d   = 1'b0;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          sclk_d = 1'b1;
          bit_d  = bit_q + 1'b1;
          if (bit_q != BIT_W'(FRAME_W - 1)) sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      sreg_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      sreg_q   <= sreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
    end
  end

  assign sclk = sclk_q;
  assign sout = active_q & sreg_q[FRAME_W-1];

endmodule

// File: rtl/dac_spi_master.sv
// Multi-channel DAC SPI master: latches a sweep request, then sends one framed
// {ctrl,data} word per enabled channel in ascending order.
module dac_spi_master import dac_spi_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int CTRL_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*CTRL_W-1:0] ch_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_sclk,
  output logic                     dac_sout,
  output logic                     dac_sync
);

  localparam int FRAME_W = frame_w(CTRL_W, DATA_W);
  localparam int CH_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int NXT_W   = clog2(NUM_CH + 1);
  localparam int CNT_MAX = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NXT_W-1:0]   nxt_q, nxt_d;
  logic [NUM_CH-1:0]  en_q;
  logic [CTRL_W-1:0]  ctrl_q [NUM_CH];
  logic [DATA_W-1:0]  data_q [NUM_CH];
  logic               accept, load, found, frameDone, shSclk, shSout;
  logic [CH_W-1:0]    sel;
  logic [FRAME_W-1:0] word;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (i >= int'(nxt_q))) begin
        found = 1'b1;
        sel   = CH_W'(i);
      end
    end
  end

  assign word = {ctrl_q[sel], data_q[sel]};

  // A start enters GAP for a single cycle so that channel selection always
  // happens in one place, whether at sweep start or between frames.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nxt_d   = nxt_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = GAP;
          cnt_d   = CNT_W'(SYNC_GAP - 1);
          nxt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(SYNC_GAP - 1)) begin
          if (found) begin
            load    = 1'b1;
            state_d = SETUP;
            cnt_d   = '0;
            nxt_d   = NXT_W'(sel) + 1'b1;
          end else begin
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) state_d = SHIFT;
        else cnt_d = cnt_q + 1'b1;
      end
      SHIFT: begin
        if (frameDone) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nxt_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nxt_q   <= nxt_d;
      if (accept) en_q <= ch_en;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i] <= ch_ctrl[i*CTRL_W +: CTRL_W];
        data_q[i] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  dac_spi_shifter #(
    .FRAME_W(FRAME_W),
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .word      (word),
    .sclk      (shSclk),
    .sout      (shSout),
    .frame_done(frameDone)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign dac_sync = !((state_q == SETUP) || (state_q == SHIFT));
  assign dac_sclk = shSclk;
  assign dac_sout = shSout;

endmodule
